// File: rtl/highscore_board.sv
// Best-times table for the reaction timer: keeps the DEPTH lowest non-zero times in ascending order,
// with sorted-shift insertion on each submit edge and a two-press arm/confirm clear.
module highscore_board #(
    parameter int W          = 24,
    parameter int DEPTH      = 4,
    parameter int CLR_WINDOW = 50000000,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1),
    localparam int TW = (CLR_WINDOW > 1) ? $clog2(CLR_WINDOW) : 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          submit_i,
    input  logic [W-1:0]  time_in_i,
    input  logic          clear_req_i,
    input  logic [IW-1:0] rd_idx_i,
    output logic [W-1:0]  rd_data_o,
    output logic [W-1:0]  best_o,
    output logic [CW-1:0] count_o,
    output logic          accepted_o,
    output logic          new_best_o,
    output logic [CW-1:0] rank_o,
    output logic          clr_armed_o
);

    typedef enum logic {S_IDLE = 1'b0, S_ARMED = 1'b1} clr_state_e;

    clr_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          submit_q, clear_q;
    logic          sub_edge, clr_edge;
    logic          do_clear, do_offer, window_last;

    logic [W-1:0]  slot_q [DEPTH];
    logic [W-1:0]  slot_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] rank_q, rank_d;
    logic [CW-1:0] pos;
    logic          accepted_q, accepted_d;
    logic          new_best_q, new_best_d;

    assign sub_edge    = submit_i & ~submit_q;
    assign clr_edge    = clear_req_i & ~clear_q;
    assign window_last = (timer_q == TW'(CLR_WINDOW - 1));

    // Edge-detect history resets high so a level held through reset is not an edge
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            submit_q <= 1'b1;
            clear_q  <= 1'b1;
        end else begin
            submit_q <= submit_i;
            clear_q  <= clear_req_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    // A press landing on the last window cycle starts a fresh arm rather than confirming
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (clr_edge) begin
                    state_d = S_ARMED;
                    timer_d = '0;
                end
            end
            S_ARMED: begin
                if (window_last) begin
                    if (clr_edge) timer_d = '0;
                    else          state_d = S_IDLE;
                end else if (clr_edge) begin
                    state_d = S_IDLE;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        clr_armed_o = (state_q == S_ARMED);
        do_clear    = (state_q == S_ARMED) && clr_edge && !window_last;
    end

    always_comb begin
        pos = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CW'(i) < count_q) && (slot_q[i] <= time_in_i)) pos = pos + CW'(1);
        end
    end

    assign do_offer = sub_edge && (time_in_i != '0) && !do_clear;

    always_comb begin
        slot_d     = slot_q;
        count_d    = count_q;
        rank_d     = rank_q;
        accepted_d = 1'b0;
        new_best_d = 1'b0;
        if (do_clear) begin
            for (int i = 0; i < DEPTH; i++) slot_d[i] = '0;
            count_d = '0;
            rank_d  = CW'(DEPTH);
        end else if (do_offer) begin
            if (pos < CW'(DEPTH)) begin
                if (pos == '0) slot_d[0] = time_in_i;
                for (int i = 1; i < DEPTH; i++) begin
                    if (CW'(i) == pos)     slot_d[i] = time_in_i;
                    else if (CW'(i) > pos) slot_d[i] = slot_q[i-1];
                end
                count_d    = (count_q == CW'(DEPTH)) ? count_q : count_q + CW'(1);
                rank_d     = pos;
                accepted_d = 1'b1;
                new_best_d = (pos == '0);
            end else begin
                rank_d = CW'(DEPTH);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            count_q    <= '0;
            rank_q     <= CW'(DEPTH);
            accepted_q <= 1'b0;
            new_best_q <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            count_q    <= count_d;
            rank_q     <= rank_d;
            accepted_q <= accepted_d;
            new_best_q <= new_best_d;
        end
    end

    assign best_o     = slot_q[0];
    assign count_o    = count_q;
    assign rank_o     = rank_q;
    assign accepted_o = accepted_q;
    assign new_best_o = new_best_q;
    assign rd_data_o  = (int'(rd_idx_i) < DEPTH) ? slot_q[rd_idx_i] : '0;

endmodule

// File: tb/tb_highscore_board.sv
// Directed bench for highscore_board: a queue-based model checked every cycle, plus literal
// expectations from hand-worked scenarios.
`timescale 1ns/100ps
module tb_highscore_board;

    localparam int W     = 24;
    localparam int DEPTH = 4;
    localparam int CLRW  = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          submit = 1'b0;
    logic [W-1:0]  time_in = '0;
    logic          clear_req = 1'b0;
    logic [1:0]    rd_idx = '0;
    logic [W-1:0]  rd_data, best;
    logic [2:0]    count, rank;
    logic          accepted, new_best, clr_armed;

    int n_checks = 0;
    int n_fail   = 0;

    highscore_board #(.W(W), .DEPTH(DEPTH), .CLR_WINDOW(CLRW)) dut (
        .clk_i(clk), .rst_i(rst), .submit_i(submit), .time_in_i(time_in),
        .clear_req_i(clear_req), .rd_idx_i(rd_idx), .rd_data_o(rd_data),
        .best_o(best), .count_o(count), .accepted_o(accepted),
        .new_best_o(new_best), .rank_o(rank), .clr_armed_o(clr_armed)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: sorted queue of times, arm tracked by cycle stamp
    int tbl[$];
    bit m_prev_sub = 1'b1, m_prev_clr = 1'b1;
    bit m_armed = 1'b0;
    int arm_at = 0;
    int cyc = 0;
    bit m_acc = 1'b0, m_nb = 1'b0;
    int m_rank = DEPTH;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tbl.delete();
            m_prev_sub = 1'b1; m_prev_clr = 1'b1;
            m_armed = 1'b0; arm_at = 0; cyc = 0;
            m_acc = 1'b0; m_nb = 1'b0; m_rank = DEPTH;
        end else begin
            bit se, ce;
            int p;
            cyc++;
            se = submit & !m_prev_sub;
            ce = clear_req & !m_prev_clr;
            m_prev_sub = submit;
            m_prev_clr = clear_req;
            m_acc = 1'b0; m_nb = 1'b0;
            if (ce && m_armed && (cyc - arm_at < CLRW)) begin
                tbl.delete();
                m_rank = DEPTH;
                m_armed = 1'b0;
            end else begin
                if (ce) begin
                    m_armed = 1'b1;
                    arm_at = cyc;
                end else if (m_armed && (cyc - arm_at >= CLRW)) begin
                    m_armed = 1'b0;
                end
                if (se && time_in != 0) begin
                    p = 0;
                    foreach (tbl[k]) if (tbl[k] <= int'(time_in)) p++;
                    if (p < DEPTH) begin
                        tbl.insert(p, int'(time_in));
                        if (tbl.size() > DEPTH) void'(tbl.pop_back());
                        m_acc = 1'b1;
                        m_nb = (p == 0);
                        m_rank = p;
                    end else begin
                        m_rank = DEPTH;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        int e_rd;
        e_rd = (int'(rd_idx) < tbl.size()) ? tbl[rd_idx] : 0;
        chk("m_best", best, (tbl.size() > 0) ? tbl[0] : 0);
        chk("m_count", count, tbl.size());
        chk("m_accepted", accepted, m_acc);
        chk("m_new_best", new_best, m_nb);
        chk("m_rank", rank, m_rank);
        chk("m_clr_armed", clr_armed, m_armed);
        chk("m_rd_data", rd_data, e_rd);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        rd_idx = rd_idx + 2'd1;
    endtask

    task automatic offer(input int t, output logic acc, output logic nb, output logic [2:0] rk);
        submit = 1'b1;
        time_in = W'(t);
        tick();
        acc = accepted; nb = new_best; rk = rank;
        submit = 1'b0;
        tick();
    endtask

    task automatic chk_slots(input string name, input int a, input int b, input int c, input int d);
        int exp_v[4];
        logic [1:0] save;
        exp_v = '{a, b, c, d};
        save = rd_idx;
        for (int i = 0; i < 4; i++) begin
            rd_idx = 2'(i);
            #1;
            chk(name, rd_data, exp_v[i]);
        end
        rd_idx = save;
    endtask

    task automatic clr_press(input int gap);
        clear_req = 1'b1; tick();
        clear_req = 1'b0;
        repeat (gap - 1) tick();
        clear_req = 1'b1; tick();
        clear_req = 1'b0; tick();
    endtask

    initial begin
        logic acc, nb;
        logic [2:0] rk;
        int n_acc;

        #1 rst = 1'b1;
        repeat (3) tick();
        chk("rst_count", count, 0);
        chk("rst_rank", rank, DEPTH);
        chk("rst_best", best, 0);
        chk("rst_armed", clr_armed, 0);
        rst = 1'b0;
        tick();

        offer(500, acc, nb, rk);
        chk("o1_acc", acc, 1); chk("o1_nb", nb, 1); chk("o1_rank", rk, 0);
        offer(300, acc, nb, rk);
        chk("o2_nb", nb, 1); chk("o2_rank", rk, 0);
        offer(800, acc, nb, rk);
        chk("o3_nb", nb, 0); chk("o3_rank", rk, 2);
        offer(300, acc, nb, rk);
        chk("o4_acc", acc, 1); chk("o4_nb", nb, 0); chk("o4_rank", rk, 1);
        chk("full_count", count, 4);
        chk_slots("slots_a", 300, 300, 500, 800);

        offer(900, acc, nb, rk);
        chk("rej_acc", acc, 0); chk("rej_nb", nb, 0); chk("rej_rank", rk, 4);
        offer(100, acc, nb, rk);
        chk("o100_rank", rk, 0); chk("o100_nb", nb, 1);
        chk_slots("slots_b", 100, 300, 300, 500);

        offer(0, acc, nb, rk);
        chk("zero_acc", acc, 0); chk("zero_rank", rk, 0);
        chk_slots("slots_zero", 100, 300, 300, 500);

        n_acc = 0;
        submit = 1'b1; time_in = W'(250);
        repeat (10) begin
            tick();
            if (accepted) n_acc++;
        end
        submit = 1'b0; tick();
        chk("hold_accepts", n_acc, 1);
        chk_slots("slots_hold", 100, 250, 300, 300);

        clr_press(7);
        chk("clr7_count", count, 0);
        chk("clr7_best", best, 0);
        chk("clr7_armed", clr_armed, 0);

        offer(600, acc, nb, rk);
        offer(400, acc, nb, rk);
        clr_press(8);
        chk("clr8_count", count, 2);
        chk("clr8_armed", clr_armed, 1);
        repeat (10) tick();
        chk("expire_armed", clr_armed, 0);

        clear_req = 1'b1; tick();
        clear_req = 1'b0; tick(); tick();
        clear_req = 1'b1; submit = 1'b1; time_in = W'(50); tick();
        chk("coinc_clr_acc", accepted, 0);
        clear_req = 1'b0; submit = 1'b0; tick();
        chk("coinc_clr_count", count, 0);

        clear_req = 1'b1; submit = 1'b1; time_in = W'(50); tick();
        chk("coinc_arm_acc", accepted, 1);
        chk("coinc_arm_rank", rank, 0);
        clear_req = 1'b0; submit = 1'b0; tick();
        chk("coinc_arm_count", count, 1);
        chk("coinc_arm_best", best, 50);
        chk("coinc_arm_armed", clr_armed, 1);
        repeat (10) tick();

        offer(10, acc, nb, rk);
        offer(20, acc, nb, rk);
        offer(30, acc, nb, rk);
        chk_slots("slots_pre_rst", 10, 20, 30, 50);
        clear_req = 1'b1; tick();
        clear_req = 1'b0; tick();
        submit = 1'b1; time_in = W'(70);
        rst = 1'b1;
        tick(); tick();
        chk("mid_rst_count", count, 0);
        chk("mid_rst_armed", clr_armed, 0);
        rst = 1'b0;
        n_acc = 0;
        repeat (4) begin
            tick();
            if (accepted) n_acc++;
        end
        chk("post_rst_accepts", n_acc, 0);
        chk("post_rst_count", count, 0);
        chk("post_rst_rank", rank, DEPTH);
        chk("post_rst_best", best, 0);
        chk("post_rst_armed", clr_armed, 0);
        submit = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/highscore_board.md
# highscore_board

Parametrised best-times table for the reaction timer game. It keeps the DEPTH lowest non-zero reaction times in ascending order; rank 0 is the high score. Each rising edge of a submit strobe offers one new time, inserted by sorted shift. A two-press arm/confirm sequence clears the table. It sits after the reaction-time counter and feeds the score display mux.

## Interface
- W, 24, width of a time value in counter ticks
- DEPTH, 4, number of table slots (≥2)
- CLR_WINDOW, 50000000, cycles the clear confirm press may follow the arm press
- IW = clog2(DEPTH), CW = clog2(DEPTH+1), TW = clog2(CLR_WINDOW) (derived localparams)

- clk  in  1  system clock; one clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- submit  in  1  level, synchronous to clk (debounced upstream); rising edge offers time_in
- time_in  in  W  reaction time; 0 means "no result" and is ignored
- clear_req  in  1  level, synchronous; rising edges drive the clear FSM
- rd_idx  in  IW  slot select for rd_data
- rd_data  out  W  slot[rd_idx], combinational; 0 if slot invalid or rd_idx ≥ DEPTH
- best  out  W  slot[0] (0 when table empty)
- count  out  CW  number of valid slots, 0..DEPTH
- accepted  out  1  one-cycle pulse: last offer entered the table
- new_best  out  1  one-cycle pulse: last offer took rank 0
- rank  out  CW  rank of last accepted offer; DEPTH when last offer rejected
- clr_armed  out  1  high while clear FSM is ARMED

## Operation
- Edge detect: submit_q, clear_q registered; sub_edge = submit & ~submit_q; clr_edge likewise.
- Table: slot[0..DEPTH-1], ascending; slots ≥ count hold 0.
- Offer (sub_edge, time_in ≠ 0): pos = number of valid slots with value ≤ time_in. On ties the new entry goes after equal entries, so an incumbent keeps its rank.
  - pos < DEPTH: slot[i] ← slot[i-1] for pos < i < DEPTH, slot[pos] ← time_in; count ← min(count+1, DEPTH). The old slot[DEPTH-1] drops out when full. accepted=1, rank=pos, new_best=(pos==0).
  - pos == DEPTH (full, not better than worst): table unchanged, accepted=0, new_best=0, rank=DEPTH.
- Offer with time_in == 0: no state change, no pulses, rank holds.
- Clear FSM, states IDLE and ARMED, timer TW bits:
  - IDLE: on clr_edge go to ARMED, timer←0.
  - ARMED: on clr_edge clear all slots to 0, count←0, rank←DEPTH, go to IDLE. Otherwise, if timer == CLR_WINDOW-1, go to IDLE. Otherwise timer increments.
- Simultaneous events:
  - Confirming clr_edge with sub_edge in the same cycle: clear wins, offer dropped, no pulses.
  - Arming clr_edge with sub_edge: offer processed normally.
  - Offers while ARMED are processed and do not disarm.

## Timing
- Reset values (async assert):
  - slots and count: 0
  - best and rd_data: 0
  - accepted and new_best: 0
  - rank: DEPTH
  - FSM: IDLE; timer: 0; clr_armed: 0
  - submit_q and clear_q: 1, so an input held high through reset release is not an edge.
- Offer latency:
  - submit low at edge k-1 and high at edge k: table, count and rank update at edge k.
  - accepted and new_best are high for exactly the cycle after edge k.
  - best and rd_data reflect the new table in that same cycle.
- Holding submit high gives exactly one offer. A new offer needs a low cycle first, so the back-to-back offer rate is one per 2 cycles.
- Clear timing:
  - Confirm edge k clears at edge k; count=0 in the following cycle.
  - An arm at edge a expires at edge a+CLR_WINDOW, with clr_armed low from then on.
  - A confirm edge at a+CLR_WINDOW-1 still clears; one at a+CLR_WINDOW re-arms instead.
- rst asserted mid-operation (including while ARMED) restores reset values immediately; no pending offer or clear survives.

## Test plan
- DEPTH=4: submit 500, 300, 800, 300 → slots {300,300,500,800}, count=4. Ranks 0,0,2,1; new_best pulses on 1st and 2nd offers only.
- Full table: submit 900 → rejected, rank=4, no pulses. Then submit 100 → slots {100,300,300,500}, rank=0, new_best=1, 800 dropped.
- time_in=0 offer, and submit held high 10 cycles with 250 → zero state change for the first; exactly one accept for the second.
- Clear with CLR_WINDOW=8: arm then confirm 7 cycles later → count=0, best=0. Arm then confirm 8 cycles later → table kept, clr_armed=1 again.
- Confirm clr_edge coincident with sub_edge(50) → table empty afterwards, accepted=0. Arming clr_edge coincident with sub_edge(50) → 50 inserted.
- Assert rst while ARMED with table full, submit held high across release → all outputs at reset values, no offer after release, clr_armed=0.
